// File: rtl/graph_pkg.sv
// Shared types and sizing helpers for the graph anomaly detector.
package graph_pkg;

  typedef enum logic [1:0] {
    TRAIN  = 2'd0,
    CALC   = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;

  function automatic int sum_width(input int data_width, input int train_win);
    return data_width + $clog2(train_win);
  endfunction

endpackage

// File: rtl/minmax_track.sv
// Running min/max of training samples with a tolerance band that clamps
// to the representable range of DATA_WIDTH.
module minmax_track
  import graph_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TOL        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  upd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  localparam int EXT_W = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] min_val;
  logic [DATA_WIDTH-1:0] max_val;

  function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a);
    logic signed [EXT_W-1:0] d;
    d = $signed({2'b00, a}) - $signed(EXT_W'(TOL));
    if (d < 0) return '0;
    return d[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a);
    logic [EXT_W-1:0] s;
    s = {2'b00, a} + EXT_W'(TOL);
    if (s > {2'b00, {DATA_WIDTH{1'b1}}}) return '1;
    return s[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_val <= '1;
      max_val <= '0;
    end else if (clr) begin
      min_val <= '1;
      max_val <= '0;
    end else if (upd) begin
      if (din < min_val) min_val <= din;
      if (din > max_val) max_val <= din;
    end
  end

  assign lo = sat_sub(min_val);
  assign hi = sat_add(max_val);

endmodule

// File: rtl/graph_anomaly_det.sv
// Learns an edge-count band over TRAIN_WIN windows, then flags out-of-band
// windows. Define GRAPH_CONSEC_FILTER_EN to require CONSEC consecutive hits.
module graph_anomaly_det
  import graph_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TRAIN_WIN  = 16,
  parameter int TOL        = 4,
  parameter int CONSEC     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_vld,
  input  logic [DATA_WIDTH-1:0] num_edges,
  input  logic                  retrain,
  output logic                  res_vld,
  output logic                  anomaly,
  output logic                  trained,
  output logic [DATA_WIDTH-1:0] baseline
);

  localparam int SUM_W  = sum_width(DATA_WIDTH, TRAIN_WIN);
  localparam int LOG_TW = $clog2(TRAIN_WIN);
  localparam int CNT_W  = LOG_TW + 1;

  state_t                state;
  logic [SUM_W-1:0]      sum;
  logic [CNT_W-1:0]      win_cnt;
  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] lo_r, hi_r;
  logic [DATA_WIDTH-1:0] mm_lo, mm_hi;
  logic                  train_upd;
  logic                  eval_en_p0;
  logic [DATA_WIDTH-1:0] eval_data_p0;
  logic                  oob_p0;
  logic                  anom_p0;

  assign train_upd = (state == TRAIN) && data_vld && !retrain;

  minmax_track #(.DATA_WIDTH(DATA_WIDTH), .TOL(TOL)) u_minmax (
    .clk (clk),
    .rst (rst),
    .clr (retrain),
    .upd (train_upd),
    .din (num_edges),
    .lo  (mm_lo),
    .hi  (mm_hi)
  );

  // Stage p0: pick the sample to judge; a held CALC-time sample goes first.
  always_comb begin
    eval_en_p0   = 1'b0;
    eval_data_p0 = num_edges;
    if (state == DETECT && !retrain) begin
      if (hold_vld) begin
        eval_en_p0   = 1'b1;
        eval_data_p0 = hold_data;
      end else if (data_vld) begin
        eval_en_p0 = 1'b1;
      end
    end
  end

  assign oob_p0 = (eval_data_p0 < lo_r) || (eval_data_p0 > hi_r);

`ifdef GRAPH_CONSEC_FILTER_EN
  localparam int RUN_W = $clog2(CONSEC + 1);
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_nxt;

  always_comb begin
    run_cnt_nxt = '0;
    if (oob_p0) run_cnt_nxt = (run_cnt == RUN_W'(CONSEC)) ? run_cnt : run_cnt + 1'b1;
  end

  assign anom_p0 = (run_cnt_nxt == RUN_W'(CONSEC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             run_cnt <= '0;
    else if (retrain)    run_cnt <= '0;
    else if (eval_en_p0) run_cnt <= run_cnt_nxt;
  end
`else
  assign anom_p0 = oob_p0;
`endif

  // Stage p1: registered result, training accumulation and state sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TRAIN;
      sum       <= '0;
      win_cnt   <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      baseline  <= '0;
      res_vld   <= 1'b0;
      anomaly   <= 1'b0;
      trained   <= 1'b0;
    end else begin
      res_vld <= eval_en_p0;
      if (eval_en_p0) anomaly <= anom_p0;
      if (retrain) begin
        state    <= TRAIN;
        sum      <= '0;
        win_cnt  <= '0;
        hold_vld <= 1'b0;
        trained  <= 1'b0;
      end else begin
        case (state)
          TRAIN: begin
            if (data_vld) begin
              sum     <= sum + SUM_W'(num_edges);
              win_cnt <= win_cnt + 1'b1;
              if (win_cnt == CNT_W'(TRAIN_WIN - 1)) state <= CALC;
            end
          end
          CALC: begin
            baseline <= DATA_WIDTH'(sum >> LOG_TW);
            lo_r     <= mm_lo;
            hi_r     <= mm_hi;
            trained  <= 1'b1;
            state    <= DETECT;
            if (data_vld) begin
              hold_vld  <= 1'b1;
              hold_data <= num_edges;
            end
          end
          DETECT: begin
            // A sample arriving while the held one is judged takes its place.
            if (hold_vld) begin
              hold_vld <= data_vld;
              if (data_vld) hold_data <= num_edges;
            end
          end
          default: state <= TRAIN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_graph_anomaly_det.sv
// Scoreboard bench for graph_anomaly_det (TRAIN_WIN=4, TOL=2, CONSEC=3).
module tb_graph_anomaly_det;

  localparam int DW     = 8;
  localparam int TW     = 4;
  localparam int TOL    = 2;
  localparam int CONSEC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_vld;
  logic [DW-1:0] num_edges;
  logic          retrain;
  logic          res_vld;
  logic          anomaly;
  logic          trained;
  logic [DW-1:0] baseline;

  graph_anomaly_det #(.DATA_WIDTH(DW), .TRAIN_WIN(TW), .TOL(TOL), .CONSEC(CONSEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_vld  (data_vld),
    .num_edges (num_edges),
    .retrain   (retrain),
    .res_vld   (res_vld),
    .anomaly   (anomaly),
    .trained   (trained),
    .baseline  (baseline)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic exp;
    int   due;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  // Reference model state
  int m_sum, m_mn, m_mx, m_lo, m_hi, m_cnt, m_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_eval(input int v);
    logic oob;
    oob = (v < m_lo) || (v > m_hi);
`ifdef GRAPH_CONSEC_FILTER_EN
    if (oob) m_cnt = (m_cnt >= CONSEC) ? CONSEC : m_cnt + 1;
    else     m_cnt = 0;
    return (m_cnt >= CONSEC);
`else
    return oob;
`endif
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (!rst && res_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_vld", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_latency", cyc, e.due);
        chk("anomaly", {31'd0, anomaly}, {31'd0, e.exp});
      end
    end
  end

  task automatic send_train(input int v);
    @(posedge clk); #1;
    data_vld = 1'b1; num_edges = DW'(v);
    m_sum += v;
    if (v < m_mn) m_mn = v;
    if (v > m_mx) m_mx = v;
    @(posedge clk); #1;
    data_vld = 1'b0;
  endtask

  task automatic model_clear();
    m_sum = 0; m_mn = 255; m_mx = 0; m_cnt = 0;
  endtask

  // calc_v >= 0 injects a sample during the CALC cycle
  task automatic train4(input int a, input int b, input int c, input int d, input int calc_v);
    model_clear();
    send_train(a); send_train(b); send_train(c); send_train(d);
    m_base = m_sum / TW;
    m_lo   = (m_mn - TOL < 0) ? 0 : m_mn - TOL;
    m_hi   = (m_mx + TOL > 255) ? 255 : m_mx + TOL;
    chk("trained_in_calc", {31'd0, trained}, 32'd0);
    if (calc_v >= 0) begin
      data_vld = 1'b1; num_edges = DW'(calc_v);
      sb.push_back('{exp: model_eval(calc_v), due: cyc + 2});
    end
    @(posedge clk); #1;
    data_vld = 1'b0;
    chk("trained_detect", {31'd0, trained}, 32'd1);
    chk("baseline", {24'd0, baseline}, m_base);
  endtask

  task automatic send_det(input int v);
    @(posedge clk); #1;
    data_vld = 1'b1; num_edges = DW'(v);
    sb.push_back('{exp: model_eval(v), due: cyc + 1});
    @(posedge clk); #1;
    data_vld = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic do_retrain();
    @(posedge clk); #1;
    retrain = 1'b1;
    @(posedge clk); #1;
    retrain = 1'b0;
    chk("trained_after_retrain", {31'd0, trained}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; data_vld = 1'b0; num_edges = '0; retrain = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_vld", {31'd0, res_vld}, 32'd0);
    chk("rst_anomaly", {31'd0, anomaly}, 32'd0);
    chk("rst_trained", {31'd0, trained}, 32'd0);
    chk("rst_baseline", {24'd0, baseline}, 32'd0);
    rst = 1'b0;

    // Basic training: band 8..15, probe both edges
    train4(10, 12, 11, 13, -1);
    send_det(15); send_det(16); send_det(8); send_det(7); send_det(11);
    drain();
`ifdef GRAPH_CONSEC_FILTER_EN
    send_det(20); send_det(20); send_det(11); send_det(20); send_det(20); send_det(20);
    drain();
`endif

    // Retrain colliding with a sample: no result, fresh training required
    @(posedge clk); #1;
    retrain = 1'b1; data_vld = 1'b1; num_edges = 8'd50;
    @(posedge clk); #1;
    retrain = 1'b0; data_vld = 1'b0;
    chk("trained_after_collision", {31'd0, trained}, 32'd0);
    train4(20, 21, 22, 23, -1);
    send_det(26); send_det(18);
    drain();

    // Band saturation at both ends of the range
    do_retrain();
    train4(0, 1, 0, 1, -1);
    send_det(0); send_det(4);
    drain();
    do_retrain();
    train4(254, 255, 255, 254, -1);
    send_det(255); send_det(251);
    drain();

    // Async reset mid-training discards partial windows
    do_retrain();
    send_train(5); send_train(99);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    chk("trained_after_rst", {31'd0, trained}, 32'd0);
    train4(20, 20, 20, 20, -1);
    send_det(18); send_det(17); send_det(22); send_det(23);
    drain();

    // Sample arriving during CALC is held and judged on DETECT entry
    do_retrain();
    train4(10, 12, 11, 13, 30);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
